// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the register-file write path: address/data widths
// fixed by the 3-to-8 write-address decoder, register depth, and the write
// arbiter FSM state encoding.
package regfile_pkg;

  localparam int REGFILE_AW    = 3;
  localparam int REGFILE_DW    = 8;
  localparam int REGFILE_DEPTH = 1 << REGFILE_AW;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } wr_state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin picker. Returns the first set bit of cand found
// by searching upward from index ptr and wrapping N-1 -> 0.
// Ports:
//   cand  [N-1:0]  candidate vector
//   ptr   [PW-1:0] search start index (0..N-1)
//   pick  [N-1:0]  one-hot selected candidate (zero when none)
//   valid          at least one candidate present
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  cand,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          valid
);

  logic [2*N-1:0] dbl_s;
  logic [N-1:0]   rot_s;
  logic [N-1:0]   low_s;
  logic [2*N-1:0] unrot_s;

  // Rotate so ptr lands at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    dbl_s   = {cand, cand} >> ptr;
    rot_s   = dbl_s[N-1:0];
    // x & -x keeps only the lowest set bit
    low_s   = rot_s & (~rot_s + {{(N-1){1'b0}}, 1'b1});
    unrot_s = {low_s, low_s} << ptr;
    pick    = unrot_s[2*N-1:N];
    valid   = |cand;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Round-robin arbiter sharing the register file's single write port among
// NREQ requesters. Grant, write strobe, address and data are registered
// together so the decoder sees glitch-free one-cycle write pulses.
// Ports:
//   CLK, RESET_N   clock, asynchronous active-low reset
//   REQ            per-requester write request
//   ADDR, DATA     per-requester packed address / data
//   FREEZE         1 = issue no new grants
//   GNT            one-hot accept pulse (same cycle as the write)
//   WE             write strobe to decoder EN
//   WADDR, WDATA   write address / data (hold last value when WE=0)
//   BUSY           write in progress or any request pending
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = REGFILE_AW,
  parameter int DW   = REGFILE_DW
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [NREQ-1:0]    REQ,
  input  logic [NREQ*AW-1:0] ADDR,
  input  logic [NREQ*DW-1:0] DATA,
  input  logic               FREEZE,
  output logic [NREQ-1:0]    GNT,
  output logic               WE,
  output logic [AW-1:0]      WADDR,
  output logic [DW-1:0]      WDATA,
  output logic               BUSY
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  wr_state_t       state_r;
  wr_state_t       state_nxt_s;
  logic [PW-1:0]   ptr_r;
  logic [NREQ-1:0] gnt_r;
  logic            we_r;
  logic [AW-1:0]   waddr_r;
  logic [DW-1:0]   wdata_r;

  logic [NREQ-1:0] cand_s;
  logic [NREQ-1:0] pick_s;
  logic            valid_s;
  logic            go_s;
  logic [PW-1:0]   idx_s;
  logic [PW-1:0]   ptr_nxt_s;
  logic [AW-1:0]   waddr_sel_s;
  logic [DW-1:0]   wdata_sel_s;

  // The requester granted this cycle is masked so a held REQ is not rewritten.
  assign cand_s = REQ & ~gnt_r;
  assign go_s   = valid_s & ~FREEZE;

  rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_pick (
    .cand  (cand_s),
    .ptr   (ptr_r),
    .pick  (pick_s),
    .valid (valid_s)
  );

  // Encode the pick index and mux the winning requester's address and data.
  always_comb begin
    idx_s       = {PW{1'b0}};
    waddr_sel_s = {AW{1'b0}};
    wdata_sel_s = {DW{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      idx_s       = idx_s | (pick_s[i] ? PW'(i) : {PW{1'b0}});
      waddr_sel_s = waddr_sel_s | (ADDR[i*AW +: AW] & {AW{pick_s[i]}});
      wdata_sel_s = wdata_sel_s | (DATA[i*DW +: DW] & {DW{pick_s[i]}});
    end
    ptr_nxt_s = (idx_s == PW'(NREQ - 1)) ? {PW{1'b0}} : (idx_s + PW'(1));
  end

  // FSM next state: a grant always leads to WRITE, otherwise IDLE.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE:  state_nxt_s = go_s ? ST_WRITE : ST_IDLE;
      ST_WRITE: state_nxt_s = go_s ? ST_WRITE : ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // State, pointer and output registers; address/data hold when no grant.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r <= ST_IDLE;
      ptr_r   <= {PW{1'b0}};
      gnt_r   <= {NREQ{1'b0}};
      we_r    <= 1'b0;
      waddr_r <= {AW{1'b0}};
      wdata_r <= {DW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (go_s) begin
        ptr_r   <= ptr_nxt_s;
        gnt_r   <= pick_s;
        we_r    <= 1'b1;
        waddr_r <= waddr_sel_s;
        wdata_r <= wdata_sel_s;
      end else begin
        gnt_r   <= {NREQ{1'b0}};
        we_r    <= 1'b0;
      end
    end
  end

  assign GNT   = gnt_r;
  assign WE    = we_r;
  assign WADDR = waddr_r;
  assign WDATA = wdata_r;
  assign BUSY  = we_r | (|REQ);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter (NREQ=4, AW=3, DW=8).
// Stimulus pushes expected writes (cycle, grant, address, data) into a
// queue; a monitor on the falling edge pops and compares every WE=1 cycle.
module tb_regfile_write_arbiter;

  logic        CLK;
  logic        RESET_N;
  logic [3:0]  REQ;
  logic [11:0] ADDR;
  logic [31:0] DATA;
  logic        FREEZE;
  logic [3:0]  GNT;
  logic        WE;
  logic [2:0]  WADDR;
  logic [7:0]  WDATA;
  logic        BUSY;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         c;
    logic [3:0] g;
    logic [2:0] a;
    logic [7:0] d;
  } exp_t;

  exp_t q[$];

  regfile_write_arbiter #(.NREQ(4), .AW(3), .DW(8)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .REQ     (REQ),
    .ADDR    (ADDR),
    .DATA    (DATA),
    .FREEZE  (FREEZE),
    .GNT     (GNT),
    .WE      (WE),
    .WADDR   (WADDR),
    .WDATA   (WDATA),
    .BUSY    (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input logic [3:0] g, input logic [2:0] a, input logic [7:0] d);
    exp_t e;
    e.c = c; e.g = g; e.a = a; e.d = d;
    q.push_back(e);
  endtask

  task automatic set_req(input int i, input logic [2:0] a, input logic [7:0] d);
    ADDR[i*3 +: 3] = a;
    DATA[i*8 +: 8] = d;
  endtask

  // Monitor: every write must match the next queued expectation.
  always @(negedge CLK) begin
    if (RESET_N) begin
      check("gnt_vs_we", {31'd0, |GNT}, {31'd0, WE});
      check("busy", {31'd0, BUSY}, {31'd0, WE | (|REQ)});
      if (WE) begin
        if (q.size() == 0) begin
          check("unexpected_write", {28'd0, GNT}, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("write_cycle", cyc, e.c);
          check("write_gnt", {28'd0, GNT}, {28'd0, e.g});
          check("write_addr", {29'd0, WADDR}, {29'd0, e.a});
          check("write_data", {24'd0, WDATA}, {24'd0, e.d});
        end
      end
    end
  end

  initial begin
    int m;
    RESET_N = 1'b1;
    REQ     = 4'b0000;
    FREEZE  = 1'b0;
    ADDR    = 12'd0;
    DATA    = 32'd0;
    for (int i = 0; i < 4; i++) set_req(i, 3'(i + 4), 8'(8'h10 * (i + 1)));
    #1 RESET_N = 1'b0;
    REQ = 4'b1111;
    #2;
    check("rst_gnt",   {28'd0, GNT},   32'd0);
    check("rst_we",    {31'd0, WE},    32'd0);
    check("rst_waddr", {29'd0, WADDR}, 32'd0);
    check("rst_wdata", {24'd0, WDATA}, 32'd0);
    check("rst_busy",  {31'd0, BUSY},  32'd1);

    // All requesting after reset release: order 0,1,2,3,0,1 back-to-back
    @(posedge CLK); @(posedge CLK); #1;
    RESET_N = 1'b1;
    m = cyc;
    push(m + 1, 4'b0001, 3'd4, 8'h10);
    push(m + 2, 4'b0010, 3'd5, 8'h20);
    push(m + 3, 4'b0100, 3'd6, 8'h30);
    push(m + 4, 4'b1000, 3'd7, 8'h40);
    push(m + 5, 4'b0001, 3'd4, 8'h10);
    push(m + 6, 4'b0010, 3'd5, 8'h20);
    repeat (6) @(posedge CLK);
    #1 REQ = 4'b0000;
    repeat (3) @(posedge CLK);

    // Single request from requester 2 (PTR=2)
    #1 set_req(2, 3'd5, 8'hA5);
    REQ = 4'b0100;
    m = cyc;
    push(m + 1, 4'b0100, 3'd5, 8'hA5);
    @(posedge CLK); #1 REQ = 4'b0000;
    repeat (3) @(posedge CLK);

    // Hold-through: requester 1 holds REQ for 6 cycles -> 3 writes
    #1 REQ = 4'b0010;
    m = cyc;
    push(m + 1, 4'b0010, 3'd5, 8'h20);
    push(m + 3, 4'b0010, 3'd5, 8'h20);
    push(m + 5, 4'b0010, 3'd5, 8'h20);
    repeat (6) @(posedge CLK);
    #1 REQ = 4'b0000;
    repeat (3) @(posedge CLK);

    // FREEZE during requester 0's write, requester 1 pending
    #1 REQ = 4'b0011;
    m = cyc;
    push(m + 1, 4'b0001, 3'd4, 8'h10);
    push(m + 4, 4'b0010, 3'd5, 8'h20);
    @(posedge CLK); #1;
    REQ    = 4'b0010;
    FREEZE = 1'b1;
    @(posedge CLK); #1;
    check("freeze_busy", {31'd0, BUSY}, 32'd1);
    check("freeze_no_we", {31'd0, WE}, 32'd0);
    @(posedge CLK); #1 FREEZE = 1'b0;
    @(posedge CLK); #1 REQ = 4'b0000;
    repeat (3) @(posedge CLK);

    // Same address from requesters 2 and 3 on consecutive cycles (PTR=2)
    #1 set_req(2, 3'd6, 8'h11);
    set_req(3, 3'd6, 8'h22);
    REQ = 4'b1100;
    m = cyc;
    push(m + 1, 4'b0100, 3'd6, 8'h11);
    push(m + 2, 4'b1000, 3'd6, 8'h22);
    @(posedge CLK); #1 REQ = 4'b1000;
    @(posedge CLK); #1 REQ = 4'b0000;
    @(posedge CLK); #1;
    check("hold_we",    {31'd0, WE},    32'd0);
    check("hold_waddr", {29'd0, WADDR}, 32'd6);
    check("hold_wdata", {24'd0, WDATA}, 32'h22);
    repeat (2) @(posedge CLK);

    // Async reset mid-write (PTR=0 -> grant 2 moves PTR to 3)
    #1 REQ = 4'b0100;
    @(posedge CLK); #2;
    check("pre_rst_we",  {31'd0, WE},  32'd1);
    check("pre_rst_gnt", {28'd0, GNT}, 32'h4);
    #1 RESET_N = 1'b0;
    #1;
    check("mid_rst_we",  {31'd0, WE},  32'd0);
    check("mid_rst_gnt", {28'd0, GNT}, 32'd0);
    REQ = 4'b1001;
    @(posedge CLK); @(posedge CLK); #1;
    RESET_N = 1'b1;
    m = cyc;
    // PTR back at 0 selects requester 0 ahead of 3
    push(m + 1, 4'b0001, 3'd4, 8'h10);
    @(posedge CLK); #1 REQ = 4'b0000;
    repeat (4) @(posedge CLK);

    check("queue_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port among NREQ independent requesters using round-robin arbitration. It drives the 3-to-8 write-address decoder (enable plus 3-bit address) and the shared write-data bus. Grants and write strobes are registered, so the decoder and register enables see glitch-free, one-cycle pulses. A FREEZE input blocks new grants while the register file is being scanned or read out.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 3, write address width; fixed by the 3-to-8 decoder
- DW, 8, register data width

Ports (clock and reset first):
- CLK  input  1  single clock; everything is rising-edge
- RESET_N  input  1  asynchronous, active-low reset
- REQ  input  NREQ  REQ[i]=1 requests one write by requester i
- ADDR  input  NREQ*AW  requester i target register at ADDR[i*AW +: AW]
- DATA  input  NREQ*DW  requester i write data at DATA[i*DW +: DW]
- FREEZE  input  1  1 = issue no new grants
- GNT  output  NREQ  one-hot, one-cycle accept pulse to requester i
- WE  output  1  write strobe; drives decoder EN
- WADDR  output  AW  write address; drives decoder W2..W0 (MSB = W2)
- WDATA  output  DW  write data to the register bank
- BUSY  output  1  1 when WE=1 or any REQ is pending

## Operation
- Two-state FSM:
  - IDLE: no valid grant candidate. Moves to WRITE when a candidate exists and FREEZE=0.
  - WRITE: WE=1 for exactly one cycle. Goes back to WRITE if another candidate exists and FREEZE=0, otherwise to IDLE.
- Candidate set: REQ[i]=1 AND GNT[i]=0. The requester granted this cycle is masked, so a requester that holds REQ through its GNT cycle is never double-written.
- Round-robin pointer PTR (log2 NREQ bits):
  - The search starts at PTR and wraps NREQ-1 to 0.
  - After granting requester k, PTR is set to (k+1) mod NREQ.
  - PTR is unchanged when no grant is issued.
- Grant registration at the edge: GNT[k], WE, WADDR=ADDR[k], WDATA=DATA[k] all update together. The write and the acknowledge are the same cycle.
- Requester handshake:
  - The requester holds REQ, ADDR and DATA stable until it samples GNT[i]=1.
  - It then drops REQ, or presents its next write; a new write is eligible no earlier than the cycle after GNT.
- When WE=0, WADDR and WDATA hold their last values. The decoder enable is the only qualifier.
- BUSY = WE | (|REQ).

## Timing
- Reset (asynchronous, RESET_N=0): GNT=0, WE=0, WADDR=0, WDATA=0, BUSY follows REQ, PTR=0, FSM=IDLE.
- Reset mid-write: WE and GNT clear immediately. The in-flight register write is lost, and requesters must re-request after reset.
- Latency: REQ rising in cycle t (port idle, FREEZE=0) gives GNT and WE in cycle t+1.
- Throughput: one write per cycle when two or more requesters alternate. A single requester holding REQ gets at most one write every two cycles.
- FREEZE=1 in cycle t: no grant in cycle t+1. A write already showing WE=1 in cycle t still completes. Pending REQs are held, not dropped.
- Simultaneous requests: at most one GNT bit is set per cycle; priority is by PTR order.
- Same ADDR from two requesters on consecutive cycles: both writes occur in grant order, and the later one wins.
- Any number of REQ bits may be high at once, including all and none.

## Structure
- Shared package regfile_pkg holds:
  - REGFILE_AW=3 and REGFILE_DW
  - localparam REGFILE_DEPTH = 1<<REGFILE_AW
  - FSM state typedef {ST_IDLE, ST_WRITE}
- Sub-module rr_pick: combinational round-robin picker with inputs candidate vector and PTR, outputs one-hot pick and valid. It is reusable for a future read-port arbiter.
- The top level holds the FSM, PTR, output registers and the address/data muxing.

## Test plan
- Reset: RESET_N=0 with REQ=4'b1111 -> GNT=0, WE=0, WADDR=0, WDATA=0. Release reset -> first GNT=4'b0001 with WADDR=ADDR[0].
- Single request: REQ[2]=1, ADDR[2]=3'd5, DATA[2]=8'hA5, dropped after GNT -> one cycle later GNT=4'b0100, WE=1, WADDR=5, WDATA=A5; WE=0 the following cycle.
- All requesting continuously with PTR=0 -> grant order 0,1,2,3,0,… with WE=1 every cycle and no requester granted twice in a row.
- Hold-through: only REQ[1] held high for 6 cycles -> GNT[1] pulses on alternate cycles (3 writes), never back-to-back.
- FREEZE asserted in the WE=1 cycle of a grant to requester 0, REQ[1] pending -> that write completes; no GNT while FREEZE=1; GNT[1] one cycle after FREEZE falls.
- Asynchronous reset asserted mid-cycle while WE=1 -> WE and GNT drop before the next edge; PTR=0 after release.
